// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the MIPS pipeline hazard controller.
// Contents:
//   REG_ZERO  - architectural $zero register index (writes to it are discarded)
//   NOP_INSTR - canonical NOP encoding (sll $0,$0,0)
//   state_e   - hazard FSM state encoding
//   hazard_e  - data-hazard classification produced by hazard_detect
//   is_data_hz - helper: class requires a data stall
package mips_pkg;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_STALL_1    = 2'd1,
    ST_FLUSH_HOLD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    HZ_NONE     = 2'd0,
    HZ_LOAD_USE = 2'd1,
    HZ_BR_ALU   = 2'd2,
    HZ_BR_LOAD  = 2'd3
  } hazard_e;

  function automatic logic is_data_hz(input logic [1:0] hz_class);
    return hz_class != HZ_NONE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// hazard_detect: combinational ID/EX register-dependency compare and hazard
// classification.
// Ports:
//   i_id_rs, i_id_rt   - source registers of the ID instruction
//   i_id_uses_rt       - ID instruction actually reads rt
//   i_id_branch        - ID instruction is a branch resolved in ID
//   i_ex_mem_read      - EX instruction is a load
//   i_ex_reg_write     - EX instruction writes a register
//   i_ex_dst           - EX destination register
//   o_match_rs/o_match_rt - EX result feeds rs / rt of the ID instruction
//   o_hz_class         - hazard_e class (none, load-use, branch-ALU, branch-load)
module hazard_detect
  import mips_pkg::*;
(
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  input  logic       i_id_branch,
  input  logic       i_ex_mem_read,
  input  logic       i_ex_reg_write,
  input  logic [4:0] i_ex_dst,
  output logic       o_match_rs,
  output logic       o_match_rt,
  output logic [1:0] o_hz_class
);

  logic    w_ex_dst_live;
  logic    w_dep;
  hazard_e w_class;

  // A destination of $zero never produces a value, so it cannot create a hazard.
  assign w_ex_dst_live = (i_ex_dst != REG_ZERO);
  assign o_match_rs    = w_ex_dst_live && (i_ex_dst == i_id_rs);
  assign o_match_rt    = w_ex_dst_live && i_id_uses_rt && (i_ex_dst == i_id_rt);
  assign w_dep         = o_match_rs || o_match_rt;

  // ALU results forward to ordinary consumers; only branches resolved in ID
  // need to wait for them.
  always_comb begin
    w_class = HZ_NONE;
    if (w_dep) begin
      if (i_ex_mem_read) begin
        w_class = i_id_branch ? HZ_BR_LOAD : HZ_LOAD_USE;
      end else if (i_id_branch && i_ex_reg_write) begin
        w_class = HZ_BR_ALU;
      end
    end
  end

  assign o_hz_class = w_class;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard FSM (stall / bubble / flush control) with
// optional performance counters.
// Optional feature: define HAZARD_PERF_EN to build the stall/flush counters;
// without it both counter ports are tied to zero and no counter flops exist.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   id_*              - ID-stage instruction operands and branch info
//   ex_*              - EX-stage instruction destination info
//   ext_stall         - external freeze (memory not ready)
//   pc_write          - PC enable
//   ifid_write        - IF/ID register enable
//   idex_bubble       - zero ID/EX control fields
//   ifid_flush        - clear IF/ID to NOP
//   stall_cnt, flush_cnt - saturating performance counters (CNT_W bits)
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_taken,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_dst,
  input  logic             ext_stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e     r_state;
  state_e     w_next;
  logic       w_match_rs;
  logic       w_match_rt;
  logic [1:0] w_hz_class;
  logic       w_stall_req;
  logic       w_data_stall;
  logic       w_flush_evt;

  hazard_detect u_detect (
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_id_uses_rt   (id_uses_rt),
    .i_id_branch    (id_branch),
    .i_ex_mem_read  (ex_mem_read),
    .i_ex_reg_write (ex_reg_write),
    .i_ex_dst       (ex_dst),
    .o_match_rs     (w_match_rs),
    .o_match_rt     (w_match_rt),
    .o_hz_class     (w_hz_class)
  );

  // Any classified hazard implies a register match; keeping both terms makes
  // the stall request read directly as "dependent and not forwardable".
  assign w_stall_req = (w_match_rs || w_match_rt) && is_data_hz(w_hz_class);

  // Next state and the two stall/flush events; events only exist in a live,
  // unfrozen cycle so the output and counter logic can use them directly.
  always_comb begin
    w_next       = r_state;
    w_data_stall = 1'b0;
    w_flush_evt  = 1'b0;
    if (!rst_n) begin
      w_next = ST_RUN;
    end else if (!ext_stall) begin
      case (r_state)
        ST_STALL_1: begin
          w_data_stall = 1'b1;
          w_next       = ST_RUN;
        end
        ST_RUN, ST_FLUSH_HOLD: begin
          if (w_stall_req) begin
            w_data_stall = 1'b1;
            w_next       = (w_hz_class == HZ_BR_LOAD) ? ST_STALL_1 : ST_RUN;
          end else if (id_taken && (r_state == ST_RUN)) begin
            // The slot behind a taken redirect is squashed, so it may not
            // redirect again; FLUSH_HOLD ignores id_taken.
            w_flush_evt = 1'b1;
            w_next      = ST_FLUSH_HOLD;
          end else begin
            w_next = ST_RUN;
          end
        end
        default: w_next = ST_RUN;
      endcase
    end
  end

  // ext_stall freezes everything, including the FSM, by holding r_state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Enables drop during reset, freeze and data stalls; reset also forces
  // bubble and flush so the pipeline starts from NOPs.
  assign pc_write    = rst_n && !ext_stall && !w_data_stall;
  assign ifid_write  = rst_n && !ext_stall && !w_data_stall;
  assign idex_bubble = !rst_n || w_data_stall;
  assign ifid_flush  = !rst_n || w_flush_evt;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating event counters; events are already masked by reset/ext_stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_data_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl.
// Output nibble checked each cycle: {pc_write, ifid_write, idex_bubble, ifid_flush}.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 16;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [3:0] O_RUN    = 4'b1100;
  localparam logic [3:0] O_STALL  = 4'b0010;
  localparam logic [3:0] O_FLUSH  = 4'b1101;
  localparam logic [3:0] O_FREEZE = 4'b0000;
  localparam logic [3:0] O_RESET  = 4'b0011;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_branch;
  logic             id_taken;
  logic             ex_mem_read;
  logic             ex_reg_write;
  logic [4:0]       ex_dst;
  logic             ext_stall;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [3:0]       outs;

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_branch    (id_branch),
    .id_taken     (id_taken),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_dst       (ex_dst),
    .ext_stall    (ext_stall),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_bubble  (idex_bubble),
    .ifid_flush   (ifid_flush),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  assign outs = {pc_write, ifid_write, idex_bubble, ifid_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic br, input logic tk, input logic mr, input logic rw,
                       input logic [4:0] dst, input logic ext);
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = uses_rt;
    id_branch    = br;
    id_taken     = tk;
    ex_mem_read  = mr;
    ex_reg_write = rw;
    ex_dst       = dst;
    ext_stall    = ext;
  endtask

  // Check outputs mid-cycle, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic [3:0] exp);
    @(negedge clk);
    chk(tag, 32'(outs), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  // Counters as seen just after the edge that closed the previous cycle.
  task automatic cnt_chk(input string tag, input int s, input int f);
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), PERF ? 32'(s) : 32'd0);
    chk({tag, "_flush_cnt"}, 32'(flush_cnt), PERF ? 32'(f) : 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step("reset_out", O_RESET);
    cnt_chk("reset", 0, 0);
    rst_n = 1'b1;

    // Idle run
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step("idle", O_RUN);

    // Load-use: lw $8 in EX, ID reads $8 -> one stall cycle
    drive(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
    step("lu_stall", O_STALL);
    drive(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step("lu_after", O_RUN);
    cnt_chk("lu", 1, 0);

    // Load to $zero never stalls
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
    step("zero_dst", O_RUN);
    // rt match ignored when rt is not read
    drive(5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
    step("rt_unused", O_RUN);
    // ALU dependency on a non-branch is forwarded
    drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    step("alu_fwd", O_RUN);
    // Branch on ALU result: one stall
    drive(5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    step("br_alu", O_STALL);
    drive(5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step("br_alu_after", O_RUN);
    cnt_chk("br_alu", 2, 0);

    // Branch on load (via rt): two stalls then run
    drive(5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
    step("br_ld_1", O_STALL);
    drive(5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step("br_ld_2", O_STALL);
    step("br_ld_run", O_RUN);
    cnt_chk("br_ld", 4, 0);

    // ext_stall for 3 cycles while in STALL_1; taken and hazards ignored
    drive(5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
    step("ext_pre", O_STALL);
    drive(5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1);
    step("ext_1", O_FREEZE);
    step("ext_2", O_FREEZE);
    cnt_chk("ext_hold", 5, 0);
    step("ext_3", O_FREEZE);
    drive(5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step("ext_release", O_STALL);
    step("ext_run", O_RUN);
    cnt_chk("ext", 6, 0);

    // Taken twice: only the first flushes
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    step("taken_1", O_FLUSH);
    step("taken_2", O_RUN);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step("taken_after", O_RUN);
    cnt_chk("taken", 6, 1);

    // Data stall outranks taken
    drive(5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);
    step("stall_over_tk", O_STALL);
    // ext_stall outranks taken
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    step("ext_over_tk", O_FREEZE);
    cnt_chk("prio", 7, 1);

    // Hazards still stall while in FLUSH_HOLD
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    step("fh_taken", O_FLUSH);
    drive(5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    step("fh_stall", O_STALL);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step("fh_after", O_RUN);
    cnt_chk("fh", 8, 2);

    // Reset for one cycle while in STALL_1 abandons the pending stall
    drive(5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
    step("rst_pre", O_STALL);
    rst_n = 1'b0;
    drive(5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step("rst_in_s1", O_RESET);
    cnt_chk("rst_in_s1", 0, 0);
    rst_n = 1'b1;
    step("rst_post", O_RUN);
    cnt_chk("rst_post", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
